// File: rtl/spi_cmd_sender.sv
// spi_cmd_sender
//   SPI mode-0 initiator. Loads a parallel MSB-aligned word and shifts the
//   first i_len bits out on csb/sclk/mosi, MSB first. All SPI outputs come
//   straight from flops.
//
// Parameters
//   DATA_W   : shift register width, maximum bits per transaction (<= 127)
//   HALF_DIV : SCLK half-period in i_clk cycles (1..255)
//
// Ports
//   i_clk      : system clock
//   i_reset_n  : asynchronous active-low reset
//   i_start    : request, taken on a posedge where i_start & o_ready
//   i_len      : bits to send, clamped to DATA_W
//   i_data     : payload, bit DATA_W-1 sent first
//   o_ready    : a start can be accepted this cycle
//   o_busy     : transaction in progress (FSM not idle)
//   o_done     : one-cycle completion pulse
//   o_csb      : chip select, active low
//   o_sclk     : SPI clock, idles low
//   o_mosi     : SPI data out
//
// Build option
//   SPI_CMD_SENDER_QUEUE_EN : adds a 2-entry {len, data} FIFO in front of
//   the FSM so starts are accepted while a transfer is running.
module spi_cmd_sender #(
  parameter int DATA_W   = 80,
  parameter int HALF_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [6:0]        i_len,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_csb,
  output logic              o_sclk,
  output logic              o_mosi
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);
  localparam logic [6:0] LEN_MAX   = 7'(DATA_W);

  state_t              state_q, state_d;
  logic [7:0]          half_q, half_d;
  logic [6:0]          bits_q, bits_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                csb_q, csb_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;

  logic                go;
  logic [6:0]          go_len;
  logic [DATA_W-1:0]   go_data;
  logic [6:0]          len_clamp;
  logic                half_end;
  logic [DATA_W-1:0]   shift_nx;

`ifdef SPI_CMD_SENDER_QUEUE_EN
  logic [6:0]          len_mem  [2];
  logic [DATA_W-1:0]   data_mem [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                push;
  logic                pop;

  always_comb begin
    push     = i_start & ready_q;
    pop      = (state_q == ST_IDLE) && (cnt_q != 2'd0);
    go       = pop;
    go_len   = len_mem[rd_ptr_q];
    go_data  = data_mem[rd_ptr_q];
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      len_mem[wr_ptr_q]  <= i_len;
      data_mem[wr_ptr_q] <= i_data;
    end
  end
`else
  always_comb begin
    go      = i_start & ready_q;
    go_len  = i_len;
    go_data = i_data;
  end
`endif

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bits_d    = bits_q;
    shift_d   = shift_q;
    csb_d     = csb_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    len_clamp = (go_len > LEN_MAX) ? LEN_MAX : go_len;
    half_end  = (half_q == HALF_LAST);
    shift_nx  = shift_q << 1;

    // Timed states run the half-period counter; it wraps exactly when the
    // state is left, so every state visit starts from zero.
    if (state_q != ST_IDLE && state_q != ST_DONE) begin
      half_d = half_end ? 8'd0 : half_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (len_clamp == 7'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SETUP;
            shift_d = go_data;
            bits_d  = len_clamp;
            csb_d   = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = go_data[DATA_W-1];
          end
        end
      end
      ST_SETUP: begin
        if (half_end) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (half_end) begin
          sclk_d = 1'b0;
          // Next bit goes out on the falling edge, giving the peripheral a
          // full half-period of setup before the following rising edge.
          if (bits_q > 7'd1) begin
            state_d = ST_LOW;
            shift_d = shift_nx;
            mosi_d  = shift_nx[DATA_W-1];
            bits_d  = bits_q - 7'd1;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_LOW: begin
        if (half_end) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (half_end) begin
          state_d = ST_GAP;
          csb_d   = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      ST_GAP: begin
        if (half_end) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
`ifdef SPI_CMD_SENDER_QUEUE_EN
    // Full FIFO can still take a push when the FSM will pop in that cycle.
    ready_d = (cnt_d != 2'd2) || (state_d == ST_IDLE);
`else
    ready_d = ~busy_d;
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      half_q  <= 8'd0;
      bits_q  <= 7'd0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bits_q  <= bits_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
  end

  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_csb   = csb_q;
  assign o_sclk  = sclk_q;
  assign o_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_cmd_sender.sv
// tb_spi_cmd_sender
//   Bench for spi_cmd_sender (default build, no queue), DATA_W=80, HALF_DIV=2.
//   Table vectors, randomized transfers against a transaction-level model,
//   and hand-written reset sequences.
module tb_spi_cmd_sender;
  localparam int DW = 80;
  localparam int HD = 2;

  logic          clk = 1'b0;
  logic          i_reset_n;
  logic          i_start;
  logic [6:0]    i_len;
  logic [DW-1:0] i_data;
  logic          o_ready, o_busy, o_done, o_csb, o_sclk, o_mosi;

  int total = 0;
  int bad   = 0;

  spi_cmd_sender #(.DATA_W(DW), .HALF_DIV(HD)) dut (
    .i_clk     (clk),
    .i_reset_n (i_reset_n),
    .i_start   (i_start),
    .i_len     (i_len),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_csb     (o_csb),
    .o_sclk    (o_sclk),
    .o_mosi    (o_mosi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]    len;
    logic [DW-1:0] data;
    int            poke;
    int            e_csb;
    int            e_done;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand80();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Transaction-level model: timing follows directly from the bit count.
  function automatic int clamp_len(int l);
    return (l > DW) ? DW : l;
  endfunction

  function automatic int model_csb(int l);
    int c;
    c = clamp_len(l);
    return (c == 0) ? 0 : (2 * c + 1) * HD;
  endfunction

  function automatic int model_done(int l);
    int c;
    c = clamp_len(l);
    return (c == 0) ? 1 : 1 + (2 * c + 2) * HD;
  endfunction

  // Runs one transfer. Entered and left at #1 after a posedge. Offsets
  // count cycles after the accepting posedge (offset 1 = first cycle after).
  task automatic do_txn(input string tag, input int len, input logic [DW-1:0] data,
                        input int poke, input int e_csb, input int e_done);
    int n, lc, csb_low, rises, wins, dones, done_off, ready_off, early_ready, bits_bad;
    logic psclk, pcsb;
    n = 0;
    while (o_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready_wait"}, 64'(n < 1000), 64'd1);
    i_start = 1'b1;
    i_len   = len[6:0];
    i_data  = data;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_len   = 7'($urandom);
    i_data  = rand80();
    lc = clamp_len(len);
    csb_low = 0; rises = 0; wins = 0; dones = 0; early_ready = 0; bits_bad = 0;
    done_off = -1; ready_off = -1;
    psclk = 1'b0; pcsb = 1'b1;
    for (int off = 1; off <= 2000; off++) begin
      if (o_csb === 1'b0 && pcsb === 1'b1) wins++;
      if (o_csb === 1'b0) csb_low++;
      if (o_csb === 1'b0 && o_sclk === 1'b1 && psclk === 1'b0) begin
        if (rises < lc && o_mosi !== data[DW-1-rises]) bits_bad++;
        rises++;
      end
      if (o_done === 1'b1) begin
        dones++;
        if (done_off < 0) done_off = off;
      end
      if (done_off < 0 && o_ready !== 1'b0) early_ready++;
      if (done_off >= 0 && ready_off < 0 && o_ready === 1'b1) ready_off = off;
      psclk = o_sclk;
      pcsb  = o_csb;
      if (done_off >= 0 && off >= done_off + 3) break;
      if (off == poke) begin
        i_start = 1'b1;
        i_len   = 7'd5;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    check({tag, "_csb_low"},     64'(csb_low),     64'(e_csb));
    check({tag, "_rises"},       64'(rises),       64'(lc));
    check({tag, "_csb_windows"}, 64'(wins),        64'((lc > 0) ? 1 : 0));
    check({tag, "_bits_bad"},    64'(bits_bad),    64'd0);
    check({tag, "_done_count"},  64'(dones),       64'd1);
    check({tag, "_done_off"},    64'(done_off),    64'(e_done));
    check({tag, "_ready_off"},   64'(ready_off),   64'(e_done + 1));
    check({tag, "_early_ready"}, 64'(early_ready), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int dones;
    logic [DW-1:0] d;

    tbl[0] = '{len: 7'd8,   data: {8'hA5, 72'h0},  poke: 0,  e_csb: 34,  e_done: 37};
    tbl[1] = '{len: 7'd80,  data: {DW{1'b1}},      poke: 0,  e_csb: 322, e_done: 325};
    tbl[2] = '{len: 7'd80,  data: {DW{1'b0}},      poke: 0,  e_csb: 322, e_done: 325};
    tbl[3] = '{len: 7'd100, data: {DW{1'b1}},      poke: 0,  e_csb: 322, e_done: 325};
    tbl[4] = '{len: 7'd0,   data: {DW{1'b1}},      poke: 0,  e_csb: 0,   e_done: 1};
    tbl[5] = '{len: 7'd8,   data: {8'hA5, 72'h0},  poke: 10, e_csb: 34,  e_done: 37};
    tbl[6] = '{len: 7'd1,   data: {1'b1, 79'h0},   poke: 0,  e_csb: 6,   e_done: 9};

    i_reset_n = 1'b0;
    i_start   = 1'b0;
    i_len     = 7'd0;
    i_data    = '0;
    #22;
    check("rst_csb",   64'(o_csb),   64'd1);
    check("rst_sclk",  64'(o_sclk),  64'd0);
    check("rst_mosi",  64'(o_mosi),  64'd0);
    check("rst_busy",  64'(o_busy),  64'd0);
    check("rst_done",  64'(o_done),  64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    #1 i_reset_n = 1'b1;
    #1;
    check("rel_ready_low", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    check("rel_ready_high", 64'(o_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      do_txn($sformatf("vec%0d", i), int'(tbl[i].len), tbl[i].data,
             tbl[i].poke, tbl[i].e_csb, tbl[i].e_done);
    end

    for (int i = 0; i < 10; i++) begin
      len = $urandom_range(0, 90);
      d   = rand80();
      do_txn($sformatf("rnd%0d", i), len, d, 0, model_csb(len), model_done(len));
    end

    // Reset during the HIGH phase of bit 3 (offsets 15..16 with HD=2).
    i_start = 1'b1;
    i_len   = 7'd8;
    i_data  = rand80();
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    check("mid_sclk_high", 64'(o_sclk), 64'd1);
    check("mid_csb_low",   64'(o_csb),  64'd0);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_csb",  64'(o_csb),  64'd1);
    check("arst_sclk", 64'(o_sclk), 64'd0);
    check("arst_busy", 64'(o_busy), 64'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done !== 1'b0) dones++;
    end
    i_reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (o_done !== 1'b0) dones++;
      @(posedge clk); #1;
    end
    check("arst_no_done", 64'(dones), 64'd0);
    do_txn("after_rst", 4, rand80(), 0, 18, 21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
